// File: rtl/seq_signed_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// Works on magnitudes and applies the sign in a final fix-up cycle.
module seq_signed_multiplier #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
    input  logic             k,
    output logic             busy,
    output logic             done,
    output logic [N+M-1:0]   y
);

    localparam int W  = N + M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [M-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    y_q, y_d;

    logic [N-1:0]    a_mag;
    logic [M-1:0]    b_mag;

    // Magnitudes fit unsigned even for the most-negative input
    assign a_mag = (k && a[N-1]) ? (~a + 1'b1) : a;
    assign b_mag = (k && b[M-1]) ? (~b + 1'b1) : b;

    // Next-state and datapath: one multiplier bit consumed per CALC cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        y_d      = y_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    mcand_d  = {{M{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    sign_d   = k & (a[N-1] ^ b[M-1]);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                y_d     = sign_q ? (~acc_q + 1'b1) : acc_q;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            y_q      <= y_d;
        end
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign y    = y_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier (N=M=8).
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_seq_signed_multiplier;

    localparam time PER = 10;
    localparam time LAT = 9 * PER + PER / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        k = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] y;

    typedef struct {
        logic [15:0] y;
        time         t;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        rst_seen = 1'b0;
    logic        armed = 1'b0;
    logic [15:0] last_y = '0;

    seq_signed_multiplier #(.N(8), .M(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #(PER / 2) clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x,
                                            input logic [7:0] z,
                                            input logic m);
        int p;
        if (m) p = int'($signed(x)) * int'($signed(z));
        else   p = int'(x) * int'(z);
        return p[15:0];
    endfunction

    always @(posedge clk) rst_seen <= !rst_n;

    // Monitor: checks reset state, each done against the queue, and y holding
    always @(negedge clk) begin
        if (rst_seen) begin
            armed  = 1'b1;
            last_y = '0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_y", y, 0);
        end else if (armed) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("y", y, e.y);
                    chk("latency", longint'($time - e.t), longint'(LAT));
                    chk("busy_at_done", busy, 0);
                    last_y = e.y;
                end
            end else begin
                chk("y_hold", y, last_y);
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] z,
                         input logic m, input logic [15:0] ey,
                         input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = z;
        k = m;
        @(posedge clk);
        e.y = ey;
        e.t = $time;
        if (push) q.push_back(e);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        k = 1'($urandom);
        chk("busy_after_accept", busy, 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rk;
        exp_t       e1;
        exp_t       e2;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'hFD, 8'h05, 1'b0, 16'd1265, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'hFF, 8'hFF, 1'b0, 16'd65025, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'h80, 8'h80, 1'b1, 16'd16384, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'h00, 8'h9A, 1'b1, 16'h0000, 1'b1);
        repeat (10) @(posedge clk);
        issue(8'h7F, 8'h00, 1'b0, 16'h0000, 1'b1);
        repeat (10) @(posedge clk);

        // Start pulsed during CALC must be ignored
        issue(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'h55;
        b = 8'hAA;
        k = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);

        // Start held high: second operation accepted from DONE
        @(negedge clk);
        start = 1'b1;
        a = 8'h0B;
        b = 8'hF9;
        k = 1'b1;
        @(posedge clk);
        e1.y = ref_mul(8'h0B, 8'hF9, 1'b1);
        e1.t = $time;
        e2.y = ref_mul(8'hC3, 8'h3C, 1'b0);
        e2.t = $time + 10 * PER;
        q.push_back(e1);
        q.push_back(e2);
        @(negedge clk);
        a = 8'hC3;
        b = 8'h3C;
        k = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);

        // Reset during CALC aborts without a done pulse
        issue(8'h44, 8'h33, 1'b1, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        issue(8'hE7, 8'h19, 1'b1, ref_mul(8'hE7, 8'h19, 1'b1), 1'b1);
        repeat (10) @(posedge clk);

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rk = 1'($urandom);
            if (i % 10 == 0) ra = 8'h80;
            if (i % 10 == 5) rb = 8'hFF;
            issue(ra, rb, rk, ref_mul(ra, rb, rk), 1'b1);
            repeat (10) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        chk("pending", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
